// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM states,
// opcode/funct constants, ALU control codes and alu_op codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: maps (alu_op, funct) to the 3-bit ALU control.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  // alu_op selects add/sub directly; only R-type execution consults funct
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      AOP_ADD: alu_control = ALU_ADD;
      AOP_SUB: alu_control = ALU_SUB;
      AOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: Moore main FSM plus ALU decoder.
// Optional build macro MC_CTRL_PERF_EN adds cycle/instruction counters.
//
// Memory handshake: the FSM presents an access (FETCH, MEMRD, MEMWR) and
// holds it every cycle; the access completes in the cycle mem_ready=1,
// and only then does the FSM advance or pulse ir_write/pc_write.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       pc_en,
  output logic       illegal_op,
`ifdef MC_CTRL_PERF_EN
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count,
`endif
  output logic [3:0] state_debug
);

  state_t     state, state_next;
  logic [1:0] alu_op;
  logic       pc_write, branch;
  logic       ir_write_raw, mem_write_raw, reg_write_raw, illegal_raw;

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= state_t'(RESET_STATE);
    else     state <= state_next;
  end

  // Next-state and per-state control outputs, defaults first
  always_comb begin
    state_next    = S_FETCH;
    iord          = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write_raw = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_op        = AOP_ADD;
    pc_write      = 1'b0;
    branch        = 1'b0;
    illegal_raw   = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b    = 2'b01;
        ir_write_raw = mem_ready;
        pc_write     = mem_ready;
        state_next   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default: begin
            state_next  = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      state_next = S_MEMRD;
        else if (opcode == OP_SW) state_next = S_MEMWR;
        else                      state_next = S_FETCH;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_MEMWR: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
        state_next    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_op     = AOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = AOP_SUB;
        branch    = 1'b1;
        pc_src    = 2'b01;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Write enables are held off for the whole time reset is asserted
  always_comb begin
    ir_write   = ir_write_raw & ~rst;
    mem_write  = mem_write_raw & ~rst;
    reg_write  = reg_write_raw & ~rst;
    illegal_op = illegal_raw & ~rst;
    pc_en      = (pc_write | (branch & zero)) & ~rst;
  end

  assign state_debug = state;

  mips_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_control)
  );

`ifdef MC_CTRL_PERF_EN
  // Free-running cycle counter and count of completed instruction fetches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (state == S_FETCH && mem_ready) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed testbench for mips_mc_control with hand-computed expectations.
module tb_mips_mc_control;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state_debug;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];

  mips_mc_control dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .iord        (iord),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .alu_control (alu_control),
    .pc_en       (pc_en),
    .illegal_op  (illegal_op),
`ifdef MC_CTRL_PERF_EN
    .cycle_count (cycle_count),
    .instr_count (instr_count),
`endif
    .state_debug (state_debug)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one clock and land just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // settle combinational outputs after an input change
  task automatic settle();
    #1;
  endtask

  // walk expected state sequence from exp_q, ticking between states;
  // reg_write must be high only in the states listed as writeback
  task automatic run_seq(input string tag);
    logic [3:0] s;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      settle();
      check({tag, "_state"}, 32'(state_debug), 32'(s));
      check({tag, "_reg_write"}, 32'(reg_write),
            32'(s == 4'd4 || s == 4'd7 || s == 4'd10));
      tick();
    end
  endtask

  int mw_cycles;
  int seq_len;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] c0, i0;
`endif

  initial begin
    // reset
    #1 rst = 1'b1;
    settle();
    check("rst_state", 32'(state_debug), 32'd0);
    check("rst_ir_write", 32'(ir_write), 32'd0);
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_alu_src_b", 32'(alu_src_b), 32'd1);
    tick();
    rst = 1'b0;
    settle();
    check("fetch_ir_write", 32'(ir_write), 32'd1);
    check("fetch_pc_en", 32'(pc_en), 32'd1);
    check("fetch_alu_ctl", 32'(alu_control), 32'(ALU_ADD));

    // fetch wait state
    mem_ready = 1'b0;
    settle();
    check("fetch_wait_ir_write", 32'(ir_write), 32'd0);
    tick();
    check("fetch_wait_state", 32'(state_debug), 32'd0);
    mem_ready = 1'b1;

    // lw, no wait states
    opcode = OP_LW;
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    run_seq("lw");
    check("lw_end_state", 32'(state_debug), 32'd0);

    // reg_write/mem_to_reg in MEMWB checked directly
    tick(); tick(); tick(); tick(); settle();
    check("lw_memwb_state", 32'(state_debug), 32'd4);
    check("lw_memwb_mem_to_reg", 32'(mem_to_reg), 32'd1);
    check("lw_memwb_reg_dst", 32'(reg_dst), 32'd0);
    tick();

    // sw with two wait cycles in MEMWR
    opcode = OP_SW;
    mw_cycles = 0;
    seq_len = 0;
    for (int i = 0; i < 20 && !(seq_len > 0 && state_debug == 4'd0); i++) begin
      if (state_debug == 4'd5) mem_ready = (mw_cycles >= 2);
      else mem_ready = 1'b1;
      settle();
      if (mem_write) mw_cycles++;
      seq_len++;
      tick();
    end
    mem_ready = 1'b1;
    check("sw_mem_write_cycles", 32'(mw_cycles), 32'd3);
    check("sw_seq_len", 32'(seq_len), 32'd6);
    check("sw_end_state", 32'(state_debug), 32'd0);

    // beq
    opcode = OP_BEQ;
    zero = 1'b1;
    tick(); tick(); settle();
    check("beq_state", 32'(state_debug), 32'd8);
    check("beq_alu_ctl", 32'(alu_control), 32'(ALU_SUB));
    check("beq_pc_src", 32'(pc_src), 32'd1);
    check("beq_pc_en_taken", 32'(pc_en), 32'd1);
    zero = 1'b0;
    settle();
    check("beq_pc_en_not_taken", 32'(pc_en), 32'd0);
    tick();
    check("beq_end_state", 32'(state_debug), 32'd0);

    // R-type: walk funct table while in EXECUTE
    opcode = OP_RTYPE;
    funct = FN_SLT;
    tick(); tick(); settle();
    check("r_exec_state", 32'(state_debug), 32'd6);
    check("r_slt_alu_ctl", 32'(alu_control), 32'(ALU_SLT));
    funct = FN_ADD; settle(); check("r_add_alu_ctl", 32'(alu_control), 32'(ALU_ADD));
    funct = FN_SUB; settle(); check("r_sub_alu_ctl", 32'(alu_control), 32'(ALU_SUB));
    funct = FN_AND; settle(); check("r_and_alu_ctl", 32'(alu_control), 32'(ALU_AND));
    funct = FN_OR;  settle(); check("r_or_alu_ctl", 32'(alu_control), 32'(ALU_OR));
    funct = 6'b000000; settle(); check("r_other_alu_ctl", 32'(alu_control), 32'(ALU_ADD));
    funct = FN_SLT;
    tick(); settle();
    check("r_aluwb_state", 32'(state_debug), 32'd7);
    check("r_aluwb_reg_dst", 32'(reg_dst), 32'd1);
    check("r_aluwb_reg_write", 32'(reg_write), 32'd1);
    tick();

    // illegal opcode
    opcode = 6'b111111;
    tick(); settle();
    check("ill_decode_pulse", 32'(illegal_op), 32'd1);
    tick(); settle();
    check("ill_state", 32'(state_debug), 32'd0);
    check("ill_pulse_gone", 32'(illegal_op), 32'd0);

    // j then addi
    opcode = OP_J;
    exp_q = '{4'd0, 4'd1, 4'd11};
    run_seq("j");
    opcode = OP_ADDI;
    exp_q = '{4'd0, 4'd1, 4'd9, 4'd10};
    run_seq("addi");
    check("addi_end_state", 32'(state_debug), 32'd0);

    // reset in the middle of a stalled MEMRD
    opcode = OP_LW;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick(); settle();
    check("memrd_wait_state", 32'(state_debug), 32'd3);
    check("memrd_iord", 32'(iord), 32'd1);
    mem_ready = 1'b1;
    rst = 1'b1;
    settle();
    check("midrst_state", 32'(state_debug), 32'd0);
    check("midrst_ir_write", 32'(ir_write), 32'd0);
    check("midrst_reg_write", 32'(reg_write), 32'd0);
    check("midrst_mem_write", 32'(mem_write), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    check("postrst_ir_write", 32'(ir_write), 32'd1);
    check("postrst_pc_en", 32'(pc_en), 32'd1);

`ifdef MC_CTRL_PERF_EN
    // j, addi, lw back-to-back: 3 + 4 + 5 cycles, 3 fetches
    c0 = cycle_count;
    i0 = instr_count;
    opcode = OP_J;    repeat (3) tick();
    opcode = OP_ADDI; repeat (4) tick();
    opcode = OP_LW;   repeat (5) tick();
    check("perf_cycles", cycle_count - c0, 32'd12);
    check("perf_instrs", instr_count - i0, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time guard
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
